hazard_control_unit: RTL and testbench
======================================

Name: hazard_control_unit

Overview:
Pipeline interlock and redirect sequencer for the decode stage.
- Tracks in-flight register writes in a scoreboard shift register.
- Stalls fetch/decode and injects bubbles on read-after-write hazards.
- Sequences a fixed-length squash after a taken jump/branch.
- Freezes the whole pipeline on an external stall request.
- Sits beside the decode stage; its outputs drive the enables of the IF/ID and ID/EX pipeline registers.

Parameters:
DEPTH, 3, number of stages from ID/EX up to and including writeback (scoreboard entries)
FLUSH_CYCLES, 1, cycles of flush_out asserted after a taken redirect (1..7)
CNT_W, 16, width of the stall performance counter

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
dec_valid  in  1  decode holds a real instruction
dec_rs  in  5  source register A
dec_rt  in  5  source register B
dec_uses_rs  in  1  instruction reads rs
dec_uses_rt  in  1  instruction reads rt
dec_wr_en  in  1  instruction writes a register
dec_wr_dest  in  5  destination register (post-mux)
jump_taken  in  1  decode resolved a taken jump/branch this cycle
ext_stall  in  1  downstream busy (memory); freezes pipeline
stall_out  out  1  hold PC and IF/ID registers
bubble_out  out  1  load ID/EX with reset (NOP) values
flush_out  out  1  squash IF/ID contents
stall_count  out  CNT_W  saturating count of hazard-stall cycles

Behaviour:
- Reset (async, active-high):
  - State = RUN; all scoreboard entries invalid; flush counter 0; stall_count 0.
  - Resulting outputs: stall_out=0, bubble_out=0, flush_out=0.
- Scoreboard: DEPTH entries of {valid, dest[4:0]}. Entry 0 is the ID/EX stage; entry DEPTH-1 is writeback.
- match(r) = r != 0 and any valid entry has dest == r.
- hazard = dec_valid & ((dec_uses_rs & match(dec_rs)) | (dec_uses_rt & match(dec_rt))).
- issue = dec_valid & !hazard & !ext_stall & state != FLUSH.
- Each clock with ext_stall=0, the scoreboard shifts:
  - entry[i+1] <= entry[i].
  - entry[0] <= {issue & dec_wr_en & (dec_wr_dest != 0), dec_wr_dest}.
  - entry[DEPTH-1] retires.
- ext_stall=1 (highest priority):
  - Scoreboard, FSM and flush counter hold.
  - stall_out=1, bubble_out=0, flush_out=0, stall_count unchanged.
- FSM states: RUN, STALL, FLUSH.
  - RUN:
    - If hazard: stall_out=1 and bubble_out=1 (same cycle, combinational); go to STALL.
    - Else if jump_taken: load flush counter with FLUSH_CYCLES; go to FLUSH.
    - Else all outputs 0.
  - STALL:
    - stall_out = bubble_out = hazard.
    - When hazard clears, the instruction issues that cycle. Then jump_taken is handled exactly as in RUN (FLUSH if taken, otherwise RUN).
  - FLUSH:
    - flush_out=1; the decode-stage instruction is treated as squashed (no issue, no scoreboard entry, hazard ignored).
    - Counter decrements each unfrozen cycle; at 1 go to RUN.
    - jump_taken is ignored in FLUSH.
- Simultaneous hazard and jump_taken: hazard wins and jump_taken is ignored. Decode re-presents the jump until operands are ready.
- stall_count increments on each cycle with hazard=1 and ext_stall=0, and saturates at all-ones.
- Register $0 never creates a hazard or a scoreboard entry.
- Outputs are combinational from registered state plus current inputs. There is no extra latency.

Optional Feature:
Macro: HAZARD_WB_BYPASS_EN.
- Defined: the entry at DEPTH-1 (writeback) is excluded from match(), because the register file writes first and reads second in the same cycle. Back-to-back dependency at distance DEPTH costs 0 stall cycles.
- Undefined: all DEPTH entries are compared. A dependency at distance DEPTH costs 1 stall cycle.

Decomposition:
- Shared package hazard_pkg holds:
  - FSM state enum (RUN=2'd0, STALL=2'd1, FLUSH=2'd2).
  - Scoreboard entry struct {valid, dest}.
  - Constant REG_ZERO = 5'd0.
- One sub-module, hazard_scoreboard: shift register plus two match comparators. The FSM and counter stay in the top module.

Test Plan:
- Back-to-back dependency: issue write $3, then read $3 on the next cycle, DEPTH=3, bypass off.
  - stall_out=1 and bubble_out=1 for 3 cycles, then issue.
  - stall_count=3.
  - With HAZARD_WB_BYPASS_EN: 2 cycles, stall_count=2.
- $0 immunity: write $0, then read $0 → no stall; scoreboard stays empty.
- Jump with FLUSH_CYCLES=2: jump_taken in RUN.
  - flush_out=1 for exactly 2 cycles.
  - A write to $5 presented during flush creates no entry; a later read of $5 does not stall.
- Hazard plus jump together: jr $4 with $4 in flight.
  - Stall first, no flush during the stall.
  - flush_out rises the cycle after the hazard clears and jump_taken is seen.
- ext_stall for 4 cycles mid-STALL: outputs stall_out=1, bubble_out=0; scoreboard and stall_count frozen; stalling resumes with the remaining count afterwards.
- Reset mid-FLUSH with full scoreboard: next cycle state RUN, all outputs 0, a read of any register issues without stall.

Source files
------------

// File: rtl/hazard_pkg.sv
// ---------------------------------------------------------------------------
// hazard_pkg
// Shared types and constants for the decode-stage hazard control unit.
//   hcu_state_t : interlock sequencer states (RUN / STALL / FLUSH)
//   sb_entry_t  : one scoreboard slot, {valid, destination register}
//   REG_ZERO    : the hard-wired zero register, never a hazard source
// ---------------------------------------------------------------------------
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } hcu_state_t;

  typedef struct packed {
    logic       valid;
    logic [4:0] dest;
  } sb_entry_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // True for any architectural register that can carry a dependency.
  function automatic logic is_real_reg(input logic [4:0] r);
    return r != REG_ZERO;
  endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// ---------------------------------------------------------------------------
// hazard_scoreboard
// Shift register tracking in-flight register writes, one slot per pipeline
// stage from ID/EX (entry 0) to writeback (entry DEPTH-1), plus the two
// source-operand comparators used by the decode-stage interlock.
//
// Build option: HAZARD_WB_BYPASS_EN -- when defined, the writeback slot is
// left out of the comparison because the register file writes before it is
// read within the same cycle.
//
// Ports:
//   clk, reset   : clock, asynchronous active-high reset (clears all slots)
//   shift_en     : advance the pipeline by one stage this cycle
//   push_valid   : an issuing instruction writes push_dest
//   push_dest    : destination register of the issuing instruction
//   rs, rt       : decode-stage source registers to compare
//   match_rs/rt  : a tracked in-flight write targets rs / rt
// ---------------------------------------------------------------------------
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int DEPTH = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       shift_en,
  input  logic       push_valid,
  input  logic [4:0] push_dest,
  input  logic [4:0] rs,
  input  logic [4:0] rt,
  output logic       match_rs,
  output logic       match_rt
);

`ifdef HAZARD_WB_BYPASS_EN
  localparam int CMP_DEPTH = DEPTH - 1;
`else
  localparam int CMP_DEPTH = DEPTH;
`endif

  sb_entry_t [DEPTH-1:0] entries;

  // Writes of $0 are dropped at the door so they can never match later.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      entries <= '0;
    end else if (shift_en) begin
      entries[0].valid <= push_valid & is_real_reg(push_dest);
      entries[0].dest  <= push_dest;
      for (int i = 1; i < DEPTH; i++) begin
        entries[i] <= entries[i-1];
      end
    end
  end

  // Reads of $0 always see the constant zero, so they never match.
  always_comb begin
    match_rs = 1'b0;
    match_rt = 1'b0;
    for (int i = 0; i < CMP_DEPTH; i++) begin
      if (entries[i].valid && entries[i].dest == rs) match_rs = 1'b1;
      if (entries[i].valid && entries[i].dest == rt) match_rt = 1'b1;
    end
    if (!is_real_reg(rs)) match_rs = 1'b0;
    if (!is_real_reg(rt)) match_rt = 1'b0;
  end

endmodule

// File: rtl/hazard_control_unit.sv
// ---------------------------------------------------------------------------
// hazard_control_unit
// Pipeline interlock and redirect sequencer beside the decode stage. Stalls
// fetch/decode with a bubble into ID/EX on read-after-write hazards,
// squashes IF/ID for FLUSH_CYCLES cycles after a taken jump/branch, and
// freezes everything while the downstream stage requests a stall.
//
// Build option: HAZARD_WB_BYPASS_EN (forwarded to hazard_scoreboard) --
// excludes the writeback slot from hazard detection.
//
// Ports:
//   clk, reset          : clock, asynchronous active-high reset
//   dec_valid           : decode holds a real instruction
//   dec_rs, dec_rt      : source registers
//   dec_uses_rs/rt      : instruction actually reads rs / rt
//   dec_wr_en           : instruction writes dec_wr_dest
//   dec_wr_dest         : destination register
//   jump_taken          : decode resolved a taken jump/branch
//   ext_stall           : downstream busy, freeze the pipeline
//   stall_out           : hold PC and IF/ID
//   bubble_out          : load ID/EX with NOP values
//   flush_out           : squash IF/ID contents
//   stall_count         : saturating count of hazard-stall cycles
// ---------------------------------------------------------------------------
module hazard_control_unit
  import hazard_pkg::*;
#(
  parameter int DEPTH        = 3,
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             dec_valid,
  input  logic [4:0]       dec_rs,
  input  logic [4:0]       dec_rt,
  input  logic             dec_uses_rs,
  input  logic             dec_uses_rt,
  input  logic             dec_wr_en,
  input  logic [4:0]       dec_wr_dest,
  input  logic             jump_taken,
  input  logic             ext_stall,
  output logic             stall_out,
  output logic             bubble_out,
  output logic             flush_out,
  output logic [CNT_W-1:0] stall_count
);

  localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES);

  hcu_state_t state;
  hcu_state_t next_state;
  logic [2:0] flush_cnt;
  logic       match_rs;
  logic       match_rt;
  logic       hazard;
  logic       issue;

  hazard_scoreboard #(
    .DEPTH (DEPTH)
  ) u_scoreboard (
    .clk        (clk),
    .reset      (reset),
    .shift_en   (~ext_stall),
    .push_valid (issue & dec_wr_en),
    .push_dest  (dec_wr_dest),
    .rs         (dec_rs),
    .rt         (dec_rt),
    .match_rs   (match_rs),
    .match_rt   (match_rt)
  );

  // The decode instruction is squashed while flushing, so its operands
  // cannot raise a hazard and it never issues.
  always_comb begin
    hazard = dec_valid & ((dec_uses_rs & match_rs) | (dec_uses_rt & match_rt))
           & (state != FLUSH);
    issue  = dec_valid & ~hazard & ~ext_stall & (state != FLUSH);
  end

  // State register; a downstream freeze holds the sequencer in place.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= RUN;
    end else if (!ext_stall) begin
      state <= next_state;
    end
  end

  // Hazard outranks a redirect: a jump waiting on its operands is simply
  // re-presented by decode, and its redirect is taken once it issues.
  always_comb begin
    next_state = state;
    case (state)
      RUN, STALL: begin
        if (hazard)          next_state = STALL;
        else if (jump_taken) next_state = FLUSH;
        else                 next_state = RUN;
      end
      FLUSH: begin
        if (flush_cnt <= 3'd1) next_state = RUN;
      end
      default: next_state = RUN;
    endcase
  end

  // Remaining squash cycles; loaded on the way into FLUSH.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flush_cnt <= 3'd0;
    end else if (!ext_stall) begin
      if (state != FLUSH && next_state == FLUSH) begin
        flush_cnt <= FLUSH_LOAD;
      end else if (state == FLUSH) begin
        flush_cnt <= flush_cnt - 3'd1;
      end
    end
  end

  // Stall and bubble react to the hazard in the same cycle; a downstream
  // freeze holds the front end without inserting bubbles.
  always_comb begin
    stall_out  = 1'b0;
    bubble_out = 1'b0;
    flush_out  = 1'b0;
    if (ext_stall) begin
      stall_out = 1'b1;
    end else begin
      case (state)
        RUN, STALL: begin
          stall_out  = hazard;
          bubble_out = hazard;
        end
        FLUSH: flush_out = 1'b1;
        default: ;
      endcase
    end
  end

  // Hazard-stall cycles counted for performance monitoring, sticking at max.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_count <= '0;
    end else if (hazard && !ext_stall && stall_count != {CNT_W{1'b1}}) begin
      stall_count <= stall_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_control_unit.sv
// ---------------------------------------------------------------------------
// tb_hazard_control_unit
// Directed stimulus with hand-computed expected outputs. The driver pushes
// the expected response of every cycle into a queue; a separate monitor on
// the falling edge pops and compares against the DUT outputs.
// ---------------------------------------------------------------------------
module tb_hazard_control_unit;

  localparam int DEPTH        = 3;
  localparam int FLUSH_CYCLES = 2;
  localparam int CNT_W        = 16;

`ifdef HAZARD_WB_BYPASS_EN
  localparam int S = 2;
`else
  localparam int S = 3;
`endif

  typedef struct packed {
    logic       s;
    logic       b;
    logic       f;
    logic [15:0] cnt;
    logic [3:0] id;
  } exp_t;

  logic             clk = 1'b0;
  logic             reset;
  logic             dec_valid;
  logic [4:0]       dec_rs;
  logic [4:0]       dec_rt;
  logic             dec_uses_rs;
  logic             dec_uses_rt;
  logic             dec_wr_en;
  logic [4:0]       dec_wr_dest;
  logic             jump_taken;
  logic             ext_stall;
  logic             stall_out;
  logic             bubble_out;
  logic             flush_out;
  logic [CNT_W-1:0] stall_count;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_compared   = 0;
  int   n_mismatched = 0;

  hazard_control_unit #(
    .DEPTH        (DEPTH),
    .FLUSH_CYCLES (FLUSH_CYCLES),
    .CNT_W        (CNT_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .dec_valid   (dec_valid),
    .dec_rs      (dec_rs),
    .dec_rt      (dec_rt),
    .dec_uses_rs (dec_uses_rs),
    .dec_uses_rt (dec_uses_rt),
    .dec_wr_en   (dec_wr_en),
    .dec_wr_dest (dec_wr_dest),
    .jump_taken  (jump_taken),
    .ext_stall   (ext_stall),
    .stall_out   (stall_out),
    .bubble_out  (bubble_out),
    .flush_out   (flush_out),
    .stall_count (stall_count)
  );

  always #5 clk = ~clk;

  function automatic string test_name(input logic [3:0] id);
    case (id)
      4'd0: return "reset";
      4'd1: return "back_to_back";
      4'd2: return "reg0_immunity";
      4'd3: return "jump_flush";
      4'd4: return "hazard_plus_jump";
      4'd5: return "ext_stall_freeze";
      4'd6: return "reset_mid_flush";
      default: return "unknown";
    endcase
  endfunction

  // Drive one cycle of decode inputs just after the rising edge and queue
  // the outputs expected for that cycle.
  task automatic apply_stimulus(
    input logic v, input logic [4:0] rs, input logic [4:0] rt,
    input logic urs, input logic urt, input logic we, input logic [4:0] wd,
    input logic j, input logic es,
    input logic xs, input logic xb, input logic xf, input int xc,
    input logic [3:0] id);
    @(posedge clk);
    #1;
    dec_valid   = v;
    dec_rs      = rs;
    dec_rt      = rt;
    dec_uses_rs = urs;
    dec_uses_rt = urt;
    dec_wr_en   = we;
    dec_wr_dest = wd;
    jump_taken  = j;
    ext_stall   = es;
    exp_q.push_back('{s: xs, b: xb, f: xf, cnt: 16'(xc), id: id});
  endtask

  task automatic check_output(input exp_t e);
    n_compared++;
    if ({stall_out, bubble_out, flush_out, stall_count} !== {e.s, e.b, e.f, e.cnt}) begin
      n_mismatched++;
      $display("[TB] FAIL %s @%0t: got stall=%b bubble=%b flush=%b count=%0d, want stall=%b bubble=%b flush=%b count=%0d",
               test_name(e.id), $time, stall_out, bubble_out, flush_out, stall_count,
               e.s, e.b, e.f, e.cnt);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      check_output(mon_e);
    end
  end

  initial begin
    reset       = 1'b1;
    dec_valid   = 1'b0;
    dec_rs      = 5'd0;
    dec_rt      = 5'd0;
    dec_uses_rs = 1'b0;
    dec_uses_rt = 1'b0;
    dec_wr_en   = 1'b0;
    dec_wr_dest = 5'd0;
    jump_taken  = 1'b0;
    ext_stall   = 1'b0;

    $display("[TB] start, expected back-to-back stall cycles = %0d", S);

    // Reset state.
    apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0);
    @(negedge clk);
    #2 reset = 1'b0;

    // Write $3 then read $3 immediately.
    apply_stimulus(1, 0, 0, 0, 0, 1, 3, 0, 0,  0, 0, 0, 0, 1);
    for (int k = 0; k < S; k++)
      apply_stimulus(1, 3, 0, 1, 0, 0, 0, 0, 0,  1, 1, 0, k, 1);
    apply_stimulus(1, 3, 0, 1, 0, 0, 0, 0, 0,  0, 0, 0, S, 1);
    apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, S, 1);

    // $0 never tracked or matched.
    apply_stimulus(1, 0, 0, 0, 0, 1, 0, 0, 0,  0, 0, 0, S, 2);
    apply_stimulus(1, 0, 0, 1, 1, 0, 0, 0, 0,  0, 0, 0, S, 2);
    apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, S, 2);

    // Taken jump: two flush cycles, writes of $5 squashed, jump ignored.
    apply_stimulus(1, 0, 0, 0, 0, 0, 0, 1, 0,  0, 0, 0, S, 3);
    apply_stimulus(1, 0, 0, 0, 0, 1, 5, 0, 0,  0, 0, 1, S, 3);
    apply_stimulus(1, 0, 0, 0, 0, 1, 5, 1, 0,  0, 0, 1, S, 3);
    apply_stimulus(1, 5, 0, 1, 0, 0, 0, 0, 0,  0, 0, 0, S, 3);

    // jr $4 with $4 in flight: stall first, flush only after it issues.
    apply_stimulus(1, 0, 0, 0, 0, 1, 4, 0, 0,  0, 0, 0, S, 4);
    for (int k = 0; k < S; k++)
      apply_stimulus(1, 4, 0, 1, 0, 0, 0, 1, 0,  1, 1, 0, S + k, 4);
    apply_stimulus(1, 4, 0, 1, 0, 0, 0, 1, 0,  0, 0, 0, 2*S, 4);
    apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 1, 2*S, 4);
    apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 1, 2*S, 4);
    apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 2*S, 4);

    // Downstream freeze for 4 cycles in the middle of a hazard stall.
    apply_stimulus(1, 0, 0, 0, 0, 1, 7, 0, 0,  0, 0, 0, 2*S, 5);
    apply_stimulus(1, 0, 7, 0, 1, 0, 0, 0, 0,  1, 1, 0, 2*S, 5);
    for (int k = 0; k < 4; k++)
      apply_stimulus(1, 0, 7, 0, 1, 0, 0, 0, 1,  1, 0, 0, 2*S + 1, 5);
    for (int k = 0; k < S - 1; k++)
      apply_stimulus(1, 0, 7, 0, 1, 0, 0, 0, 0,  1, 1, 0, 2*S + 1 + k, 5);
    apply_stimulus(1, 0, 7, 0, 1, 0, 0, 0, 0,  0, 0, 0, 3*S, 5);

    // Fill the scoreboard, enter FLUSH, then reset asynchronously.
    apply_stimulus(1, 0, 0, 0, 0, 1, 1, 0, 0,  0, 0, 0, 3*S, 6);
    apply_stimulus(1, 0, 0, 0, 0, 1, 2, 0, 0,  0, 0, 0, 3*S, 6);
    apply_stimulus(1, 0, 0, 0, 0, 1, 3, 1, 0,  0, 0, 0, 3*S, 6);
    apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 1, 3*S, 6);
    @(negedge clk);
    #2 reset = 1'b1;
    #2 reset = 1'b0;
    apply_stimulus(1, 1, 2, 1, 1, 0, 0, 0, 0,  0, 0, 0, 0, 6);
    apply_stimulus(1, 3, 0, 1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 6);
    apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 6);

    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_compared++;
      n_mismatched++;
      $display("[TB] FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
